slerp_bracket_feeder: RTL and testbench
=======================================

// Module: slerp_bracket_feeder
// PURPOSE
// - Producer side of the SLERP interface: buffers timestamped IMU orientation samples and answers timestamp queries.
// - Finds the two samples bracketing a query time and computes t = (tq-ta)/(tb-ta) in Q16.16.
// - Presents q1, q2 and t to slerp_calculator with a valid/ready handshake.
// - Sits between the IMU quaternion stream and slerp_calculator inside the IMU synchronizer.
// PARAMETERS
// - DEPTH  8   ring-buffer entries (power of 2, >=2)
// - TS_W   32  timestamp width, unsigned ticks
// PORTS
// - clk        in   1        system clock
// - rst_n      in   1        asynchronous active-low reset
// - s_valid    in   1        sample valid
// - s_ready    out  1        sample accepted when s_valid&s_ready
// - s_ts       in   TS_W     sample timestamp
// - s_q        in   32x[0:3] sample quaternion, Q16.16
// - q_valid    in   1        query valid
// - q_ready    out  1        query accepted when q_valid&q_ready
// - q_ts       in   TS_W     query timestamp
// - m_valid    out  1        result valid
// - m_ready    in   1        downstream accepts the result
// - q1         out  32x[0:3] older bracketing quaternion
// - q2         out  32x[0:3] newer bracketing quaternion
// - t          out  32       interpolation parameter, Q16.16, range 0..0x0001_0000
// - status     out  2        00 ok, 01 clamped low, 10 clamped high, 11 buffer empty
// - ts_err     out  1        sticky: non-monotonic sample dropped
// BEHAVIOUR
// - Reset: all outputs 0 except s_ready=1 and q_ready=1. Buffer emptied, FSM=IDLE, ts_err=0.
// - Reset mid-query aborts the query. No result is produced.
// - Storage: ring buffer with wr_ptr and count. Oldest entry = wr_ptr-count (mod DEPTH).
// - Sample rules:
//   - s_ready = (state==IDLE).
//   - If full, an accepted sample overwrites the oldest entry.
//   - s_ts <= newest ts with count>0: sample dropped, ts_err set until reset. Stored timestamps are strictly increasing.
// - q_ready = (state==IDLE).
// - Sample and query in the same IDLE cycle: the sample is written first and is visible to the query.
// - FSM:
//   - IDLE: on query accept, latch q_ts. If count==0, go to OUT with status=11, q1=q2=0, t=0. Otherwise go to SEARCH.
//   - SEARCH: examine one entry per cycle, oldest to newest. Find i such that ts[i] <= q_ts < ts[i+1].
//     - q_ts < oldest ts: q1=q2=oldest, t=0, status=01, go to OUT.
//     - q_ts >= newest ts: q1=q2=newest, t=0, status=10, go to OUT. An exact newest match is a high clamp.
//     - Bracket found: ta/q1 = entry i, tb/q2 = entry i+1, go to DIV.
//   - DIV: restoring divide computing num = (q_ts-ta)<<16 over den = (tb-ta), one bit per cycle, 17 cycles.
//     - num < den<<16, so t < 0x0001_0000. q_ts==ta gives t=0.
//     - Datapath widths are TS_W+17 bits. den is never 0.
//   - OUT: m_valid=1 with q1, q2, t and status held stable until m_ready. Then go to IDLE.
//     - m_valid rises no earlier than the cycle after entering OUT.
//     - m_ready held high: IDLE is entered on the next edge and a new query can be accepted that cycle.
// - Latency from query accept to m_valid:
//   - empty buffer: 2 cycles
//   - clamp: <= DEPTH+2 cycles
//   - bracket: <= DEPTH+19 cycles
// CONFIGURATION
// - BRACKET_PRUNE_EN defined:
//   - After a status=00 result is accepted, entries older than entry i are discarded (count reduced). Entry i remains the oldest.
//   - Clamped and empty results prune nothing.
// - BRACKET_PRUNE_EN undefined: entries are removed only by overwrite when full.
// TESTING
// - Reset, then a query at ts=100 -> status=11, t=0, q1=q2=0, m_valid after 2 cycles.
// - Samples ts=100 (q=A) and ts=200 (q=B), query ts=150 -> status=00, q1=A, q2=B, t=0x0000_8000.
// - Same buffer, query ts=50 -> status=01, q1=q2=A, t=0. Query ts=250 -> status=10, q1=q2=B, t=0.
// - Samples ts=0,300; query ts=100 -> t=0x0000_5555. Query ts=0 -> t=0.
// - DEPTH+1 samples ts=10,20,...,90 -> entry ts=10 overwritten. Query ts=15 -> status=01, q1=q2=ts20 entry.
//   Then sample ts=85 -> dropped, ts_err=1.
// - Hold m_ready=0 for 5 cycles -> outputs stable, s_ready=q_ready=0. Assert rst_n=0 mid-DIV -> m_valid=0, buffer empty.
//   With BRACKET_PRUNE_EN: samples 100,200,300, query 250, accept result -> count=2, oldest ts=200.

Source files
------------

// File: rtl/slerp_bracket_feeder.sv
// slerp_bracket_feeder: timestamped quaternion ring buffer that answers time queries
// with the two bracketing samples and a Q16.16 factor t. Optional feature: BRACKET_PRUNE_EN.
module slerp_bracket_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [TS_W-1:0]      s_ts,
  input  logic [0:3][31:0]     s_q,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [TS_W-1:0]      q_ts,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [0:3][31:0]     q1,
  output logic [0:3][31:0]     q2,
  output logic [31:0]          t,
  output logic [1:0]           status,
  output logic                 ts_err
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = TS_W + 17;

  typedef enum logic [1:0] {IDLE, SEARCH, DIV, OUT} state_t;
  state_t state, state_nx;

  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [0:3][31:0] q_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic [TS_W-1:0]  tq;
  logic [TS_W-1:0]  ta;
  logic [TS_W-1:0]  den;
  logic [AW-1:0]    k;
  logic [4:0]       div_cnt;
  logic [DW-1:0]    rem;
  logic [16:0]      dvd;
  logic [15:0]      quot;
`ifdef BRACKET_PRUNE_EN
  logic [AW-1:0]    brk;
`endif

  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    newest_addr;
  logic [TS_W-1:0]  e_ts;
  logic [0:3][31:0] e_q;
  logic [TS_W-1:0]  newest_ts;
  logic             s_acc, s_drop, s_wr, q_acc, q_empty;
  logic             below, is_last;
  logic [TS_W-1:0]  d_num;
  logic [TS_W-1:0]  d_den;
  logic [DW-1:0]    rem_sh, rem_nx;
  logic             div_ge;
  logic [16:0]      quot_nx;

  assign s_ready     = (state == IDLE);
  assign q_ready     = (state == IDLE);

  // k walks entries relative to the oldest one; oldest = wr_ptr - count (mod DEPTH)
  assign rd_addr     = wr_ptr - count[AW-1:0] + k;
  assign newest_addr = wr_ptr - AW'(1);
  assign e_ts        = ts_mem[rd_addr];
  assign e_q         = q_mem[rd_addr];
  assign newest_ts   = ts_mem[newest_addr];

  assign s_acc   = s_valid && (state == IDLE);
  assign s_drop  = s_acc && (count != '0) && (s_ts <= newest_ts);
  assign s_wr    = s_acc && !s_drop;
  assign q_acc   = q_valid && (state == IDLE);
  assign q_empty = (count == '0) && !s_wr;

  assign below   = tq < e_ts;
  assign is_last = ({1'b0, k} + CW'(1)) == count;
  assign d_num   = tq - ta;
  assign d_den   = e_ts - ta;

  // Dividend is (tq-ta)<<16 with (tq-ta) < den, so the upper bits yield quotient 0 and
  // the divide starts with remainder (tq-ta)>>1 and 17 bits {d[0],16'b0} still to shift in.
  assign rem_sh  = {rem[DW-2:0], dvd[16]};
  assign div_ge  = rem[DW-1] | (rem_sh >= {17'b0, den});
  assign rem_nx  = div_ge ? (rem_sh - {17'b0, den}) : rem_sh;
  assign quot_nx = {quot, div_ge};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (q_acc) state_nx = q_empty ? OUT : SEARCH;
      SEARCH: begin
        if (below)        state_nx = (k == '0) ? OUT : DIV;
        else if (is_last) state_nx = OUT;
      end
      DIV:    if (div_cnt == 5'd16) state_nx = OUT;
      OUT:    if (m_valid && m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_wr) begin
      ts_mem[wr_ptr] <= s_ts;
      q_mem[wr_ptr]  <= s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      count   <= '0;
      ts_err  <= 1'b0;
      m_valid <= 1'b0;
      q1      <= '0;
      q2      <= '0;
      t       <= '0;
      status  <= 2'b00;
      tq      <= '0;
      ta      <= '0;
      den     <= '0;
      k       <= '0;
      div_cnt <= '0;
      rem     <= '0;
      dvd     <= '0;
      quot    <= '0;
`ifdef BRACKET_PRUNE_EN
      brk     <= '0;
`endif
    end else begin
      state <= state_nx;

      if (s_drop) ts_err <= 1'b1;
      if (s_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) count <= count + CW'(1);
      end

      case (state)
        IDLE: begin
          if (q_acc) begin
            tq <= q_ts;
            k  <= '0;
            if (q_empty) begin
              q1     <= '0;
              q2     <= '0;
              t      <= '0;
              status <= 2'b11;
            end
          end
        end
        SEARCH: begin
          if (below) begin
            if (k == '0) begin
              q1     <= e_q;
              q2     <= e_q;
              t      <= '0;
              status <= 2'b01;
            end else begin
              // q1/ta already hold the previous (lower) entry
              q2      <= e_q;
              den     <= d_den;
              rem     <= {18'b0, d_num[TS_W-1:1]};
              dvd     <= {d_num[0], 16'b0};
              quot    <= '0;
              div_cnt <= '0;
`ifdef BRACKET_PRUNE_EN
              brk     <= k - AW'(1);
`endif
            end
          end else begin
            ta <= e_ts;
            q1 <= e_q;
            if (is_last) begin
              q2     <= e_q;
              t      <= '0;
              status <= 2'b10;
            end else begin
              k <= k + AW'(1);
            end
          end
        end
        DIV: begin
          rem     <= rem_nx;
          dvd     <= {dvd[15:0], 1'b0};
          quot    <= quot_nx[15:0];
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd16) begin
            t      <= {15'b0, quot_nx};
            status <= 2'b00;
          end
        end
        OUT: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
`ifdef BRACKET_PRUNE_EN
            if (status == 2'b00) count <= count - CW'(brk);
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_slerp_bracket_feeder.sv
// Bench for slerp_bracket_feeder: directed vector table, hand sequences for backpressure,
// same-cycle sample/query and reset in flight, then random traffic against a queue model.
module tb_slerp_bracket_feeder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [TS_W-1:0]  s_ts = '0;
  logic [0:3][31:0] s_q = '0;
  logic             q_valid = 1'b0;
  logic             q_ready;
  logic [TS_W-1:0]  q_ts = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [0:3][31:0] q1, q2;
  logic [31:0]      t;
  logic [1:0]       status;
  logic             ts_err;

  slerp_bracket_feeder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_ts(s_ts), .s_q(s_q),
    .q_valid(q_valid), .q_ready(q_ready), .q_ts(q_ts),
    .m_valid(m_valid), .m_ready(m_ready),
    .q1(q1), .q2(q2), .t(t), .status(status), .ts_err(ts_err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0]      m_ts [$];
  logic [0:3][31:0] m_q  [$];
  bit               m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [0:3][31:0] qof(input logic [31:0] ts);
    logic [0:3][31:0] r;
    r[0] = ts ^ 32'hA5A5_0000;
    r[1] = ts + 32'd1;
    r[2] = ts * 32'd3;
    r[3] = ~ts;
    return r;
  endfunction

  // Reference model: sorted list of stored samples, oldest first.
  function automatic void model_sample(input logic [31:0] ts, input logic [0:3][31:0] q);
    if (m_ts.size() > 0 && ts <= m_ts[m_ts.size()-1]) begin
      m_err = 1'b1;
    end else begin
      m_ts.push_back(ts);
      m_q.push_back(q);
      if (m_ts.size() > DEPTH) begin
        void'(m_ts.pop_front());
        void'(m_q.pop_front());
      end
    end
  endfunction

  function automatic void model_query(input logic [31:0] tq, output logic [1:0] st,
      output logic [31:0] tv, output logic [0:3][31:0] a, output logic [0:3][31:0] b,
      output int idx);
    int n;
    longint unsigned num, dn;
    n = m_ts.size();
    st = 2'b11; tv = '0; a = '0; b = '0; idx = 0;
    if (n == 0) return;
    if (tq < m_ts[0]) begin
      st = 2'b01; a = m_q[0]; b = m_q[0];
    end else if (tq >= m_ts[n-1]) begin
      st = 2'b10; a = m_q[n-1]; b = m_q[n-1];
    end else begin
      for (int j = 0; j < n - 1; j++) begin
        if (m_ts[j] <= tq && tq < m_ts[j+1]) begin
          num = longint'(tq - m_ts[j]) << 16;
          dn  = longint'(m_ts[j+1] - m_ts[j]);
          tv  = 32'(num / dn);
          st  = 2'b00; a = m_q[j]; b = m_q[j+1]; idx = j;
        end
      end
    end
  endfunction

  function automatic void model_prune(input logic [1:0] st, input int idx);
`ifdef BRACKET_PRUNE_EN
    if (st == 2'b00) begin
      for (int j = 0; j < idx; j++) begin
        void'(m_ts.pop_front());
        void'(m_q.pop_front());
      end
    end
`else
    if (st == 2'b00 && idx < 0) m_err = 1'b1;
`endif
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!q_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!q_ready) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; q_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {m_valid, s_ready, q_ready, ts_err, status}, 6'b011000);
    chk("rst_t", t, 32'd0);
    chk("rst_q", {q1 | q2}, 128'd0);
    rst_n = 1'b1;
    m_ts.delete();
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic do_sample(input logic [31:0] ts, input logic [0:3][31:0] q);
    wait_idle();
    s_valid = 1'b1; s_ts = ts; s_q = q;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_sample(ts, q);
  endtask

  task automatic do_query(input logic [31:0] tq, input int hold, input bit with_s,
      input logic [31:0] sts, input logic [0:3][31:0] sq,
      output logic [1:0] st, output logic [31:0] tv, output logic [0:3][31:0] a,
      output logic [0:3][31:0] b, output int lat);
    wait_idle();
    if (with_s) begin
      s_valid = 1'b1; s_ts = sts; s_q = sq;
    end
    q_valid = 1'b1; q_ts = tq;
    @(posedge clk); #1;
    s_valid = 1'b0; q_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    st = status; tv = t; a = q1; b = q2;
    if (!m_valid) begin
      chk("m_valid_timeout", 1'b0, 1'b1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("hold_stable_%0d", h),
          {m_valid, s_ready, q_ready, status == st, t == tv, q1 == a, q2 == b}, 7'b1001111);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("after_accept", {m_valid, q_ready}, 2'b01);
  endtask

  function automatic bit lat_ok(input logic [1:0] st, input int lat);
    if (st == 2'b11) return lat == 2;
    if (st == 2'b00) return lat >= 2 && lat <= int'(DEPTH) + 19;
    return lat >= 2 && lat <= int'(DEPTH) + 2;
  endfunction

  task automatic run_q(input string nm, input logic [31:0] tq, input int hold, input bit with_s,
      input logic [31:0] sts, input logic [0:3][31:0] sq);
    logic [1:0] est, gst;
    logic [31:0] et, gt;
    logic [0:3][31:0] ea, eb, ga, gb;
    int idx, lat;
    if (with_s) model_sample(sts, sq);
    model_query(tq, est, et, ea, eb, idx);
    do_query(tq, hold, with_s, sts, sq, gst, gt, ga, gb, lat);
    chk({nm, "_status"}, gst, est);
    chk({nm, "_t"}, gt, et);
    chk({nm, "_q1"}, ga, ea);
    chk({nm, "_q2"}, gb, eb);
    chk({nm, "_lat"}, lat_ok(est, lat), 1'b1);
    model_prune(est, idx);
  endtask

  typedef struct {
    int          op;   // 0 reset, 1 sample, 2 query, 3 check ts_err
    logic [31:0] ts;
    logic [1:0]  st;
    logic [31:0] tv;
    logic [31:0] q1ts;
    logic [31:0] q2ts;
  } vec_t;
  vec_t vecs [$];

  function automatic void add(input int op, input logic [31:0] ts, input logic [1:0] st,
      input logic [31:0] tv, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.op = op; v.ts = ts; v.st = st; v.tv = tv; v.q1ts = a; v.q2ts = b;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [1:0] gst;
    logic [31:0] gt;
    logic [0:3][31:0] ga, gb, ea, eb;
    int lat;
    logic [31:0] last;

    add(0, 0, 0, 0, 0, 0);
    add(2, 100, 2'b11, 0, 0, 0);
    add(1, 100, 0, 0, 0, 0);   add(1, 200, 0, 0, 0, 0);
    add(2, 150, 2'b00, 32'h0000_8000, 100, 200);
    add(2, 50,  2'b01, 0, 100, 100);
    add(2, 250, 2'b10, 0, 200, 200);
    add(2, 200, 2'b10, 0, 200, 200);
    add(2, 100, 2'b00, 0, 100, 200);
    add(2, 199, 2'b00, 32'h0000_FD70, 100, 200);
    add(0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);     add(1, 300, 0, 0, 0, 0);
    add(2, 100, 2'b00, 32'h0000_5555, 0, 300);
    add(2, 0,   2'b00, 0, 0, 300);
    add(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(1, 32'(i * 10), 0, 0, 0, 0);
    add(3, 0, 2'b00, 0, 0, 0);
    add(2, 15, 2'b01, 0, 20, 20);
    add(2, 90, 2'b10, 0, 90, 90);
    add(2, 55, 2'b00, 32'h0000_8000, 50, 60);
    add(1, 85, 0, 0, 0, 0);
    add(3, 0, 2'b01, 0, 0, 0);
    add(1, 95, 0, 0, 0, 0);
    add(3, 0, 2'b01, 0, 0, 0);
    add(2, 95, 2'b10, 0, 95, 95);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        0: do_reset();
        1: do_sample(vecs[i].ts, qof(vecs[i].ts));
        2: begin
          do_query(vecs[i].ts, 0, 1'b0, '0, '0, gst, gt, ga, gb, lat);
          ea = (vecs[i].st == 2'b11) ? '0 : qof(vecs[i].q1ts);
          eb = (vecs[i].st == 2'b11) ? '0 : qof(vecs[i].q2ts);
          chk($sformatf("vec%0d_status", i), gst, vecs[i].st);
          chk($sformatf("vec%0d_t", i), gt, vecs[i].tv);
          chk($sformatf("vec%0d_q1", i), ga, ea);
          chk($sformatf("vec%0d_q2", i), gb, eb);
          chk($sformatf("vec%0d_lat", i), lat_ok(vecs[i].st, lat), 1'b1);
        end
        default: begin
          @(negedge clk);
          chk($sformatf("vec%0d_ts_err", i), ts_err, vecs[i].st[0]);
        end
      endcase
    end

    // Backpressure: result must hold while m_ready stays low.
    do_reset();
    do_sample(100, qof(100));
    do_sample(200, qof(200));
    run_q("hold", 150, 5, 1'b0, '0, '0);

    // Sample and query in the same cycle: the new sample is visible to the query.
    do_reset();
    run_q("same_cyc_a", 100, 0, 1'b1, 100, qof(100));
    run_q("same_cyc_b", 150, 0, 1'b1, 200, qof(200));

    // Reset while dividing: no result, buffer empty afterwards.
    wait_idle();
    q_valid = 1'b1; q_ts = 150;
    @(posedge clk); #1;
    q_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_div_busy", {m_valid, q_ready}, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("mid_div_rst", {m_valid, s_ready, q_ready}, 3'b011);
    @(negedge clk);
    rst_n = 1'b1;
    m_ts.delete(); m_q.delete(); m_err = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_div_no_result", m_valid, 1'b0);
    run_q("post_rst_empty", 100, 0, 1'b0, '0, '0);

    // Pruning behaviour (model decides what is expected in either build).
    do_reset();
    do_sample(100, qof(100));
    do_sample(200, qof(200));
    do_sample(300, qof(300));
    run_q("prune_q250", 250, 0, 1'b0, '0, '0);
    run_q("prune_q150", 150, 0, 1'b0, '0, '0);
    run_q("prune_q200", 200, 0, 1'b0, '0, '0);

    // Random traffic.
    do_reset();
    last = 32'd1000;
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [31:0] ts, tq;
      logic [0:3][31:0] rq;
      int lo, hi;
      r = int'($urandom_range(0, 9));
      rq = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ts = last - 32'($urandom_range(0, 20));
      else if ($urandom_range(0, 9) == 0) ts = last + 32'($urandom_range(1, 1 << 20));
      else ts = last + 32'($urandom_range(1, 40));
      if (m_ts.size() > 0) begin
        lo = (m_ts[0] > 30) ? int'(m_ts[0]) - 30 : 0;
        hi = int'(m_ts[m_ts.size()-1]) + 30;
      end else begin
        lo = 0; hi = 3000;
      end
      tq = 32'($urandom_range(lo, hi));
      if (r < 6) begin
        do_sample(ts, rq);
        @(negedge clk);
        chk($sformatf("rnd%0d_ts_err", it), ts_err, m_err);
      end else if (r < 9) begin
        run_q($sformatf("rnd%0d", it), tq, int'($urandom_range(0, 2)), 1'b0, '0, '0);
      end else begin
        run_q($sformatf("rnd%0d_sq", it), tq, 0, 1'b1, ts, rq);
      end
      if (m_ts.size() > 0) last = m_ts[m_ts.size()-1];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
